// File: rtl/ysyx_23060240_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, then waits for pc_update.
// Optional performance counters are compiled in when IFU_PERF_EN is defined.
module ysyx_23060240_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_update,
    input  logic [31:0] dnpc,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        valid_ifu,
    output logic        fetch_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [2:0]  arprot,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cyc
`endif
);

    typedef enum logic [1:0] {
        S_AR   = 2'd0,
        S_R    = 2'd1,
        S_EXEC = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;

    // Next-state and output-register computation for the fetch FSM
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        case (state_q)
            S_AR: begin
                rready_d = 1'b0;
                // arvalid_q is low only in the first cycle after reset
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            S_R: begin
                arvalid_d = 1'b0;
                if (rvalid) begin
                    rready_d = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = S_EXEC;
                    if (rresp == 2'b00) begin
                        inst_d = rdata;
                    end else begin
                        inst_d = NOP_INST;
                        err_d  = 1'b1;
                    end
                end else begin
                    rready_d = 1'b1;
                end
            end
            S_EXEC: begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                if (pc_update) begin
                    pc_d      = {dnpc[31:2], 2'b00};
                    arvalid_d = 1'b1;
                    state_d   = S_AR;
                end else begin
                    state_d = S_EXEC;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                state_d   = S_AR;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_AR;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0000_0000;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    assign pc        = pc_q;
    assign inst      = inst_q;
    assign valid_ifu = valid_q;
    assign fetch_err = err_q;
    assign araddr    = pc_q;
    assign arvalid   = arvalid_q;
    assign arprot    = 3'b100;
    assign rready    = rready_q;

`ifdef IFU_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cyc_q, stall_cyc_d;

    // Stall cycles are those with an AR or R handshake outstanding
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, valid_q};
        stall_cyc_d = stall_cyc_q + {31'd0, (arvalid_q | rready_q)};
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cyc_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cyc = stall_cyc_q;
`endif

endmodule

// File: tb/tb_ysyx_23060240_ifu.sv
// Directed testbench for ysyx_23060240_ifu; inputs driven and outputs sampled on negedge.
module tb_ysyx_23060240_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_update;
    logic [31:0] dnpc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid_ifu;
    logic        fetch_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [2:0]  arprot;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cyc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060240_ifu dut (
        .clk       (clk),
        .rst       (rst),
        .pc_update (pc_update),
        .dnpc      (dnpc),
        .pc        (pc),
        .inst      (inst),
        .valid_ifu (valid_ifu),
        .fetch_err (fetch_err),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .arprot    (arprot),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expects arvalid high on entry; holds arready low for ar_wait cycles then handshakes.
    task automatic ar_phase(input int ar_wait, input logic [31:0] addr);
        check("ar_valid_entry", {31'd0, arvalid}, 32'd1);
        check("ar_addr_entry", araddr, addr);
        check("ar_prot", {29'd0, arprot}, 32'd4);
        for (int i = 0; i < ar_wait; i++) begin
            arready = 1'b0;
            @(negedge clk);
            check("ar_valid_hold", {31'd0, arvalid}, 32'd1);
            check("ar_addr_hold", araddr, addr);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("ar_valid_drop", {31'd0, arvalid}, 32'd0);
        check("r_ready_rise", {31'd0, rready}, 32'd1);
    endtask

    // Waits r_wait cycles then returns one R beat; ends on the valid_ifu cycle.
    task automatic r_phase(input int r_wait, input logic [31:0] word, input logic [1:0] resp,
                           input logic [31:0] exp_pc, input logic [31:0] exp_inst,
                           input logic exp_err, input logic pcu_in_r);
        for (int i = 0; i < r_wait; i++) begin
            pc_update = pcu_in_r;
            dnpc      = 32'h1234_5678;
            @(negedge clk);
            check("r_ready_hold", {31'd0, rready}, 32'd1);
            check("r_no_valid", {31'd0, valid_ifu}, 32'd0);
            check("r_no_ar", {31'd0, arvalid}, 32'd0);
        end
        pc_update = pcu_in_r;
        dnpc      = 32'h1234_5678;
        rvalid    = 1'b1;
        rdata     = word;
        rresp     = resp;
        @(negedge clk);
        rvalid    = 1'b0;
        pc_update = 1'b0;
        rdata     = 32'hFFFF_FFFF;
        rresp     = 2'b00;
        check("valid_pulse", {31'd0, valid_ifu}, 32'd1);
        check("inst", inst, exp_inst);
        check("pc", pc, exp_pc);
        check("r_ready_drop", {31'd0, rready}, 32'd0);
        check("fetch_err", {31'd0, fetch_err}, {31'd0, exp_err});
    endtask

    task automatic idle(input int n, input logic [31:0] exp_pc);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_valid", {31'd0, valid_ifu}, 32'd0);
            check("idle_arvalid", {31'd0, arvalid}, 32'd0);
            check("idle_rready", {31'd0, rready}, 32'd0);
            check("idle_pc", pc, exp_pc);
        end
    endtask

    task automatic pc_upd(input logic [31:0] np, input logic [31:0] exp_addr);
        pc_update = 1'b1;
        dnpc      = np;
        @(negedge clk);
        pc_update = 1'b0;
        dnpc      = 32'h0000_0000;
        check("upd_arvalid", {31'd0, arvalid}, 32'd1);
        check("upd_araddr", araddr, exp_addr);
        check("upd_pc", pc, exp_addr);
    endtask

    initial begin
        rst       = 1'b1;
        pc_update = 1'b0;
        dnpc      = 32'h0000_0000;
        arready   = 1'b0;
        rdata     = 32'h0000_0000;
        rresp     = 2'b00;
        rvalid    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_inst", inst, 32'h0000_0000);
        check("rst_valid", {31'd0, valid_ifu}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_rready", {31'd0, rready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: first fetch after reset
        ar_phase(0, 32'h8000_0000);
        r_phase(0, 32'h0000_0297, 2'b00, 32'h8000_0000, 32'h0000_0297, 1'b0, 1'b0);
        idle(2, 32'h8000_0000);

        // 2: sequential fetches, low dnpc bits cleared
        pc_upd(32'h8000_0004, 32'h8000_0004);
        ar_phase(0, 32'h8000_0004);
        r_phase(0, 32'h0010_0093, 2'b00, 32'h8000_0004, 32'h0010_0093, 1'b0, 1'b0);
        idle(1, 32'h8000_0004);
        pc_upd(32'h8000_0103, 32'h8000_0100);
        ar_phase(0, 32'h8000_0100);
        r_phase(0, 32'h0020_0113, 2'b00, 32'h8000_0100, 32'h0020_0113, 1'b0, 1'b0);

        // 3: pc_update in the valid_ifu cycle is accepted; then backpressure
        pc_upd(32'h8000_0104, 32'h8000_0104);
        ar_phase(5, 32'h8000_0104);
        r_phase(4, 32'hABCD_0001, 2'b00, 32'h8000_0104, 32'hABCD_0001, 1'b0, 1'b0);
        idle(1, 32'h8000_0104);

        // 4: error response, then sticky error through an OKAY fetch
        pc_upd(32'h8000_0108, 32'h8000_0108);
        ar_phase(0, 32'h8000_0108);
        r_phase(0, 32'hDEAD_BEEF, 2'b10, 32'h8000_0108, 32'h0000_0013, 1'b1, 1'b0);
        idle(1, 32'h8000_0108);
        pc_upd(32'h8000_010C, 32'h8000_010C);
        ar_phase(0, 32'h8000_010C);
        r_phase(0, 32'h0000_0297, 2'b00, 32'h8000_010C, 32'h0000_0297, 1'b1, 1'b0);
        idle(1, 32'h8000_010C);

        // 5: pc_update during S_R is ignored; reset in S_R restarts fetch
        pc_upd(32'h8000_0110, 32'h8000_0110);
        ar_phase(0, 32'h8000_0110);
        r_phase(2, 32'h0000_0517, 2'b00, 32'h8000_0110, 32'h0000_0517, 1'b1, 1'b1);
        idle(2, 32'h8000_0110);
        pc_upd(32'h8000_0114, 32'h8000_0114);
        ar_phase(0, 32'h8000_0114);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_r_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_r_rready", {31'd0, rready}, 32'd0);
        check("rst_r_pc", pc, 32'h8000_0000);
        check("rst_r_err", {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        ar_phase(0, 32'h8000_0000);
        r_phase(0, 32'h0000_0297, 2'b00, 32'h8000_0000, 32'h0000_0297, 1'b0, 1'b0);
        idle(1, 32'h8000_0000);

`ifdef IFU_PERF_EN
        // 6: three fetches with two-cycle arready delay, 4 stall cycles each
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ar_phase(2, 32'h8000_0000);
        r_phase(0, 32'h0000_0001, 2'b00, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
        idle(1, 32'h8000_0000);
        pc_upd(32'h8000_0004, 32'h8000_0004);
        ar_phase(2, 32'h8000_0004);
        r_phase(0, 32'h0000_0002, 2'b00, 32'h8000_0004, 32'h0000_0002, 1'b0, 1'b0);
        idle(1, 32'h8000_0004);
        pc_upd(32'h8000_0008, 32'h8000_0008);
        ar_phase(2, 32'h8000_0008);
        r_phase(0, 32'h0000_0003, 2'b00, 32'h8000_0008, 32'h0000_0003, 1'b0, 1'b0);
        idle(1, 32'h8000_0008);
        check("perf_fetch_cnt", perf_fetch_cnt, 32'd3);
        check("perf_stall_cyc", perf_stall_cyc, 32'd12);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
